// File: rtl/zap_ldm_stm_sequencer_if.sv
// Handshake/bus bundle between the predecode path and the LDM/STM sequencer.
//   master: drives the instruction fields, stall and clear; observes the micro-ops.
//   slave : the sequencer; observes the instruction, drives ready and the micro-op stream.
interface zap_ldm_stm_sequencer_if #(
    parameter int unsigned OFFSET_W = 13
);
    logic                       i_start;
    logic [15:0]                i_reglist;
    logic [3:0]                 i_base;
    logic                       i_load;
    logic                       i_up;
    logic                       i_pre;
    logic                       i_writeback;
    logic                       i_stall;
    logic                       i_clear;

    logic                       o_ready;
    logic                       o_uop_valid;
    logic [3:0]                 o_uop_reg;
    logic signed [OFFSET_W-1:0] o_uop_offset;
    logic                       o_uop_load;
    logic                       o_uop_last;
    logic                       o_pc_load;
    logic                       o_wb_valid;
    logic [3:0]                 o_wb_reg;
    logic signed [OFFSET_W-1:0] o_wb_offset;

    modport master (
        output i_start, i_reglist, i_base, i_load, i_up, i_pre, i_writeback, i_stall, i_clear,
        input  o_ready, o_uop_valid, o_uop_reg, o_uop_offset, o_uop_load, o_uop_last,
               o_pc_load, o_wb_valid, o_wb_reg, o_wb_offset
    );

    modport slave (
        input  i_start, i_reglist, i_base, i_load, i_up, i_pre, i_writeback, i_stall, i_clear,
        output o_ready, o_uop_valid, o_uop_reg, o_uop_offset, o_uop_load, o_uop_last,
               o_pc_load, o_wb_valid, o_wb_reg, o_wb_offset
    );
endinterface

// File: rtl/zap_ldm_stm_sequencer.sv
// Expands one LDM/STM instruction into single-register transfer micro-ops,
// lowest register first at ascending byte offsets from the base, optionally
// followed by one base-writeback micro-op. Busy while a transfer is in flight.
// Ports:
//   i_clk   : clock
//   i_reset : synchronous active-high reset
//   bus     : slave side of zap_ldm_stm_sequencer_if (instruction in, micro-ops out)
module zap_ldm_stm_sequencer #(
    parameter int unsigned OFFSET_W = 13
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    zap_ldm_stm_sequencer_if.slave        bus
);
    localparam int unsigned REG_W  = 4;
    localparam int unsigned LIST_W = 16;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned N4_W   = 7;
    localparam logic signed [OFFSET_W-1:0] FOUR = OFFSET_W'(4);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t                     state;
    logic [LIST_W-1:0]          mask_q;     // registers not yet issued
    logic [REG_W-1:0]           base_q;
    logic                       do_wb_q;
    logic signed [OFFSET_W-1:0] wb_off_q;

    logic                       ready_q;
    logic                       uop_valid_q;
    logic [REG_W-1:0]           uop_reg_q;
    logic signed [OFFSET_W-1:0] uop_offset_q;
    logic                       uop_load_q;
    logic                       uop_last_q;
    logic                       pc_load_q;
    logic                       wb_valid_q;
    logic [REG_W-1:0]           wb_reg_q;
    logic signed [OFFSET_W-1:0] wb_offset_q;

    logic [LIST_W-1:0]          sel_mask_c;
    logic [LIST_W-1:0]          rem_mask_c;
    logic [REG_W-1:0]           sel_reg_c;
    logic [CNT_W-1:0]           count_c;
    logic [N4_W-1:0]            n4_c;
    logic signed [OFFSET_W-1:0] n4_s_c;
    logic signed [OFFSET_W-1:0] first_off_c;
    logic                       wb_cond_c;

    // Index of the lowest set bit; 0 for an empty mask (never used then).
    function automatic logic [REG_W-1:0] lowest_set(input logic [LIST_W-1:0] m);
        lowest_set = '0;
        for (int i = int'(LIST_W) - 1; i >= 0; i--) begin
            if (m[i]) lowest_set = REG_W'(i);
        end
    endfunction

    function automatic logic [CNT_W-1:0] count_ones(input logic [LIST_W-1:0] m);
        count_ones = '0;
        for (int i = 0; i < int'(LIST_W); i++) begin
            count_ones = count_ones + CNT_W'(m[i]);
        end
    endfunction

    // Next register to issue: from the incoming list on capture, else from the remaining mask.
    always_comb begin
        sel_mask_c = (state == S_IDLE) ? bus.i_reglist : mask_q;
        sel_reg_c  = lowest_set(sel_mask_c);
        rem_mask_c = sel_mask_c & (sel_mask_c - LIST_W'(1));
        count_c    = count_ones(bus.i_reglist);
        n4_c       = {count_c, 2'b00};
        n4_s_c     = OFFSET_W'(n4_c);
        wb_cond_c  = bus.i_writeback && !(bus.i_load && bus.i_reglist[bus.i_base]);
    end

    // Offset of the first (lowest) register relative to the base.
    always_comb begin
        first_off_c = '0;
        unique case ({bus.i_up, bus.i_pre})
            2'b10:   first_off_c = '0;
            2'b11:   first_off_c = FOUR;
            2'b00:   first_off_c = FOUR - n4_s_c;
            default: first_off_c = -n4_s_c;
        endcase
    end

    // Sequencer FSM with registered micro-op outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= S_IDLE;
            mask_q       <= '0;
            base_q       <= '0;
            do_wb_q      <= 1'b0;
            wb_off_q     <= '0;
            ready_q      <= 1'b1;
            uop_valid_q  <= 1'b0;
            uop_reg_q    <= '0;
            uop_offset_q <= '0;
            uop_load_q   <= 1'b0;
            uop_last_q   <= 1'b0;
            pc_load_q    <= 1'b0;
            wb_valid_q   <= 1'b0;
            wb_reg_q     <= '0;
            wb_offset_q  <= '0;
        end else if (bus.i_clear) begin
            state       <= S_IDLE;
            mask_q      <= '0;
            do_wb_q     <= 1'b0;
            ready_q     <= 1'b1;
            uop_valid_q <= 1'b0;
            pc_load_q   <= 1'b0;
            wb_valid_q  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    // An empty list is dropped: nothing to issue, stay ready.
                    if (bus.i_start && (count_c != '0)) begin
                        base_q       <= bus.i_base;
                        do_wb_q      <= wb_cond_c;
                        wb_off_q     <= bus.i_up ? n4_s_c : -n4_s_c;
                        ready_q      <= 1'b0;
                        uop_valid_q  <= 1'b1;
                        uop_reg_q    <= sel_reg_c;
                        uop_offset_q <= first_off_c;
                        uop_load_q   <= bus.i_load;
                        uop_last_q   <= (rem_mask_c == '0);
                        pc_load_q    <= bus.i_load && (sel_reg_c == REG_W'(15));
                        mask_q       <= rem_mask_c;
                        state        <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (!bus.i_stall) begin
                        if (mask_q != '0) begin
                            uop_reg_q    <= sel_reg_c;
                            uop_offset_q <= uop_offset_q + FOUR;
                            uop_last_q   <= (rem_mask_c == '0);
                            pc_load_q    <= uop_load_q && (sel_reg_c == REG_W'(15));
                            mask_q       <= rem_mask_c;
                        end else begin
                            uop_valid_q <= 1'b0;
                            pc_load_q   <= 1'b0;
                            if (do_wb_q) begin
                                wb_valid_q  <= 1'b1;
                                wb_reg_q    <= base_q;
                                wb_offset_q <= wb_off_q;
                                state       <= S_WB;
                            end else begin
                                ready_q <= 1'b1;
                                state   <= S_IDLE;
                            end
                        end
                    end
                end
                S_WB: begin
                    if (!bus.i_stall) begin
                        wb_valid_q <= 1'b0;
                        ready_q    <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    ready_q     <= 1'b1;
                    uop_valid_q <= 1'b0;
                    wb_valid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_ready      = ready_q;
    assign bus.o_uop_valid  = uop_valid_q;
    assign bus.o_uop_reg    = uop_reg_q;
    assign bus.o_uop_offset = uop_offset_q;
    assign bus.o_uop_load   = uop_load_q;
    assign bus.o_uop_last   = uop_last_q;
    assign bus.o_pc_load    = pc_load_q;
    assign bus.o_wb_valid   = wb_valid_q;
    assign bus.o_wb_reg     = wb_reg_q;
    assign bus.o_wb_offset  = wb_offset_q;
endmodule
